// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer
//   Command stage in front of an SPI master controller. Host commands (write/read,
//   8-bit address, 8-bit data) are queued in a small FIFO and issued one at a time:
//   a one-cycle start strobe, then a wait for done/err guarded by a timeout watchdog.
//   Each command returns exactly one response over a valid/ready port.
//
// Ports
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o         host command handshake (ready = FIFO not full)
//   cmd_wr_i, cmd_addr_i, cmd_din_i command fields
//   rsp_valid_o/rsp_ready_i         response handshake
//   rsp_dout_o, rsp_err_o,          response data (0 for writes/errors), error flag,
//   rsp_timeout_o                   timeout flag
//   busy_o                          FIFO non-empty or sequencer not idle
//   spi_start_o                     one-cycle launch strobe to the controller
//   spi_wr_o, spi_addr_o, spi_din_o registered command fields, stable through the wait
//   spi_dout_i, spi_done_i,         controller read data, completion and error pulses
//   spi_err_i

module spi_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_wr_i,
    input  logic [7:0] cmd_addr_i,
    input  logic [7:0] cmd_din_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_dout_o,
    output logic       rsp_err_o,
    output logic       rsp_timeout_o,
    output logic       busy_o,
    output logic       spi_start_o,
    output logic       spi_wr_o,
    output logic [7:0] spi_addr_o,
    output logic [7:0] spi_din_o,
    input  logic [7:0] spi_dout_i,
    input  logic       spi_done_i,
    input  logic       spi_err_i
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);
    localparam logic [15:0] TimerLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    // ---------------------------------------------------------------- command FIFO
    logic [16:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop;
    logic [16:0]   head;

    state_e state_q, state_d;

    assign cmd_ready_o = (count_q != FullCount);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = (state_q == StIssue);
    assign head        = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_wr_i, cmd_addr_i, cmd_din_i};
    end

    // ---------------------------------------------------------------- sequencer
    logic [15:0] timer_q, timer_d;
    logic        spi_start_q, spi_start_d;
    logic        spi_wr_q, spi_wr_d;
    logic [7:0]  spi_addr_q, spi_addr_d;
    logic [7:0]  spi_din_q, spi_din_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [7:0]  rsp_dout_q, rsp_dout_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            spi_start_q   <= 1'b0;
            spi_wr_q      <= 1'b0;
            spi_addr_q    <= '0;
            spi_din_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_dout_q    <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            spi_start_q   <= spi_start_d;
            spi_wr_q      <= spi_wr_d;
            spi_addr_q    <= spi_addr_d;
            spi_din_q     <= spi_din_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_dout_q    <= rsp_dout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        spi_start_d   = 1'b0;
        spi_wr_d      = spi_wr_q;
        spi_addr_d    = spi_addr_q;
        spi_din_d     = spi_din_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_dout_d    = rsp_dout_q;

        unique case (state_q)
            StIdle: begin
                // Fields and strobe are registered on the way into ISSUE so that the
                // controller sees them together during the ISSUE cycle.
                if (count_q != '0) begin
                    state_d     = StIssue;
                    spi_start_d = 1'b1;
                    spi_wr_d    = head[16];
                    spi_addr_d  = head[15:8];
                    spi_din_d   = head[7:0];
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                timer_d = timer_q + 16'd1;
                if (spi_err_i) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_dout_d    = '0;
                    state_d       = StResp;
                end else if (spi_done_i) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_dout_d    = spi_wr_q ? 8'h00 : spi_dout_i;
                    state_d       = StResp;
                end else if (timer_q == TimerLast) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_dout_d    = '0;
                    state_d       = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_dout_d    = '0;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign spi_start_o   = spi_start_q;
    assign spi_wr_o      = spi_wr_q;
    assign spi_addr_o    = spi_addr_q;
    assign spi_din_o     = spi_din_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign rsp_dout_o    = rsp_dout_q;
    assign busy_o        = (count_q != '0) || (state_q != StIdle);

endmodule
